// File: rtl/parking_request_scheduler.sv
// Queues park-in/out requests and per-floor evacuations; offers one command at a time, evacuations first.
// Request at edge N is stored at N and offered after N+1; the offer holds until req_ready, then waits for op_done or the timeout.
module parking_request_scheduler #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_mode,
  input  logic        out_mode,
  input  logic [15:0] license_plate,
  input  logic        leakage,
  input  logic [2:0]  leakage_floor,
  input  logic        req_ready,
  input  logic        op_done,
  output logic        req_valid,
  output logic [1:0]  req_kind,
  output logic [15:0] req_plate,
  output logic [2:0]  req_floor,
  output logic        busy,
  output logic [2:0]  queue_count,
  output logic        drop_pulse,
  output logic        timeout_pulse
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0] KIND_IN   = 2'b00;
  localparam logic [1:0] KIND_EVAC = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_OFFER, S_BUSY} state_t;

  state_t      state_q, state_d;
  logic [16:0] fifo_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;
  logic [7:0]  mask_q, mask_d;
  logic [1:0]  kind_q, kind_d;
  logic [15:0] plate_q, plate_d;
  logic [2:0]  floor_q, floor_d;
  logic [7:0]  timer_q, timer_d;
  logic        drop_q, drop_d;
  logic        tmo_q, tmo_d;

  logic        req_ok, full, accept, pop, push;
  logic [2:0]  low_floor;
  logic [16:0] head;

  assign req_ok = (in_mode ^ out_mode) && (license_plate != 16'd0);
  assign full   = (count_q == 3'(DEPTH));
  assign accept = (state_q == S_OFFER) && req_ready;
  assign pop    = accept && (kind_q != KIND_EVAC);
  // A full FIFO still takes a new entry when the head leaves on the same edge.
  assign push   = req_ok && (!full || pop);
  assign head   = fifo_q[rd_ptr_q];

  always_comb begin
    low_floor = 3'd0;
    for (int f = 7; f >= 1; f--) begin
      if (mask_q[f]) low_floor = 3'(f);
    end
  end

  always_comb begin
    drop_d   = (in_mode && out_mode)
             || ((in_mode || out_mode) && (license_plate == 16'd0))
             || (req_ok && full && !pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
    mask_d = mask_q;
    if (accept && (kind_q == KIND_EVAC)) mask_d[floor_q] = 1'b0;
    if (leakage && (leakage_floor != 3'd0)) mask_d[leakage_floor] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    plate_d = plate_q;
    floor_d = floor_q;
    timer_d = timer_q;
    tmo_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mask_q != 8'd0) begin
          kind_d  = KIND_EVAC;
          plate_d = 16'd0;
          floor_d = low_floor;
          state_d = S_OFFER;
        end else if (count_q != 3'd0) begin
          kind_d  = {1'b0, head[16]};
          plate_d = head[15:0];
          floor_d = 3'd0;
          state_d = S_OFFER;
        end
      end
      S_OFFER: begin
        if (req_ready) begin
          state_d = S_BUSY;
          timer_d = 8'd0;
        end
      end
      S_BUSY: begin
        if (op_done) begin
          state_d = S_IDLE;
        end else if (timer_q == 8'(TIMEOUT - 1)) begin
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 3'd0;
      mask_q   <= 8'd0;
      kind_q   <= KIND_IN;
      plate_q  <= 16'd0;
      floor_q  <= 3'd0;
      timer_q  <= 8'd0;
      drop_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mask_q   <= mask_d;
      kind_q   <= kind_d;
      plate_q  <= plate_d;
      floor_q  <= floor_d;
      timer_q  <= timer_d;
      drop_q   <= drop_d;
      tmo_q    <= tmo_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clock) begin
    if (push) fifo_q[wr_ptr_q] <= {out_mode, license_plate};
  end

  assign req_valid     = (state_q == S_OFFER);
  assign busy          = (state_q == S_BUSY);
  assign req_kind      = kind_q;
  assign req_plate     = plate_q;
  assign req_floor     = floor_q;
  assign queue_count   = count_q;
  assign drop_pulse    = drop_q;
  assign timeout_pulse = tmo_q;

endmodule

// File: tb/tb_parking_request_scheduler.sv
// Directed bench for parking_request_scheduler with DEPTH=4, TIMEOUT=64.
module tb_parking_request_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_mode = 1'b0;
  logic        out_mode = 1'b0;
  logic [15:0] license_plate = 16'd0;
  logic        leakage = 1'b0;
  logic [2:0]  leakage_floor = 3'd0;
  logic        req_ready = 1'b0;
  logic        op_done = 1'b0;
  logic        req_valid;
  logic [1:0]  req_kind;
  logic [15:0] req_plate;
  logic [2:0]  req_floor;
  logic        busy;
  logic [2:0]  queue_count;
  logic        drop_pulse;
  logic        timeout_pulse;

  int checks = 0;
  int errors = 0;

  parking_request_scheduler #(.DEPTH(4), .TIMEOUT(64)) dut (
    .clock(clock), .reset(reset), .in_mode(in_mode), .out_mode(out_mode),
    .license_plate(license_plate), .leakage(leakage), .leakage_floor(leakage_floor),
    .req_ready(req_ready), .op_done(op_done), .req_valid(req_valid), .req_kind(req_kind),
    .req_plate(req_plate), .req_floor(req_floor), .busy(busy), .queue_count(queue_count),
    .drop_pulse(drop_pulse), .timeout_pulse(timeout_pulse)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h exp 0", req_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h exp 0", busy); end
    checks++; if (queue_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", queue_count); end
    checks++; if (req_kind !== 2'b00 || req_plate !== 16'h0 || req_floor !== 3'd0) begin errors++; $display("FAIL reset_cmd got %0h/%0h/%0h exp 0/0/0", req_kind, req_plate, req_floor); end
    checks++; if (drop_pulse !== 1'b0 || timeout_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulses got %0h/%0h exp 0/0", drop_pulse, timeout_pulse); end
  endtask

  task automatic test_single_in();
    req_ready = 1'b1;
    in_mode = 1'b1; license_plate = 16'h9423;
    tick();
    in_mode = 1'b0; license_plate = 16'h0;
    checks++; if (queue_count !== 3'd1 || req_valid !== 1'b0) begin errors++; $display("FAIL single_stored got cnt=%0d vld=%0h exp cnt=1 vld=0", queue_count, req_valid); end
    tick();
    checks++; if (req_valid !== 1'b1 || req_kind !== 2'b00 || req_plate !== 16'h9423 || req_floor !== 3'd0) begin errors++; $display("FAIL single_offer got vld=%0h kind=%0h plate=%0h floor=%0h exp 1/0/9423/0", req_valid, req_kind, req_plate, req_floor); end
    tick();
    checks++; if (busy !== 1'b1 || req_valid !== 1'b0 || queue_count !== 3'd0) begin errors++; $display("FAIL single_busy got busy=%0h vld=%0h cnt=%0d exp 1/0/0", busy, req_valid, queue_count); end
    op_done = 1'b1; tick(); op_done = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_done got busy=%0h exp 0", busy); end
    tick();
    checks++; if (req_valid !== 1'b0 || queue_count !== 3'd0) begin errors++; $display("FAIL single_idle got vld=%0h cnt=%0d exp 0/0", req_valid, queue_count); end
    req_ready = 1'b0;
  endtask

  task automatic test_priority();
    req_ready = 1'b0;
    in_mode = 1'b1; license_plate = 16'h1111;
    tick();
    in_mode = 1'b0; out_mode = 1'b1; license_plate = 16'h8754;
    tick();
    out_mode = 1'b0; license_plate = 16'h0;
    checks++; if (req_valid !== 1'b1 || req_plate !== 16'h1111 || queue_count !== 3'd2) begin errors++; $display("FAIL prio_first got vld=%0h plate=%0h cnt=%0d exp 1/1111/2", req_valid, req_plate, queue_count); end
    req_ready = 1'b1;
    tick();
    leakage = 1'b1; leakage_floor = 3'd5; tick();
    leakage_floor = 3'd3; tick();
    leakage = 1'b0; leakage_floor = 3'd0;
    checks++; if (busy !== 1'b1 || queue_count !== 3'd1) begin errors++; $display("FAIL prio_busy got busy=%0h cnt=%0d exp 1/1", busy, queue_count); end
    op_done = 1'b1; tick(); op_done = 1'b0;
    tick();
    checks++; if (req_valid !== 1'b1 || req_kind !== 2'b10 || req_floor !== 3'd3 || req_plate !== 16'h0) begin errors++; $display("FAIL prio_evac3 got vld=%0h kind=%0h floor=%0d plate=%0h exp 1/2/3/0", req_valid, req_kind, req_floor, req_plate); end
    tick();
    op_done = 1'b1; tick(); op_done = 1'b0;
    tick();
    checks++; if (req_valid !== 1'b1 || req_kind !== 2'b10 || req_floor !== 3'd5) begin errors++; $display("FAIL prio_evac5 got vld=%0h kind=%0h floor=%0d exp 1/2/5", req_valid, req_kind, req_floor); end
    tick();
    op_done = 1'b1; tick(); op_done = 1'b0;
    tick();
    checks++; if (req_valid !== 1'b1 || req_kind !== 2'b01 || req_plate !== 16'h8754 || req_floor !== 3'd0) begin errors++; $display("FAIL prio_out got vld=%0h kind=%0h plate=%0h floor=%0d exp 1/1/8754/0", req_valid, req_kind, req_plate, req_floor); end
    tick();
    checks++; if (busy !== 1'b1 || queue_count !== 3'd0) begin errors++; $display("FAIL prio_drain got busy=%0h cnt=%0d exp 1/0", busy, queue_count); end
    op_done = 1'b1; tick(); op_done = 1'b0;
    req_ready = 1'b0;
    tick();
  endtask

  task automatic test_overflow_and_full_pop();
    logic [15:0] exp_plates [4];
    exp_plates[0] = 16'h1002; exp_plates[1] = 16'h1003;
    exp_plates[2] = 16'h1004; exp_plates[3] = 16'h1006;
    req_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      in_mode = 1'b1; license_plate = 16'h1000 + 16'(i);
      tick();
    end
    in_mode = 1'b0; license_plate = 16'h0;
    checks++; if (drop_pulse !== 1'b1 || queue_count !== 3'd4) begin errors++; $display("FAIL ovf_drop got drop=%0h cnt=%0d exp 1/4", drop_pulse, queue_count); end
    checks++; if (req_valid !== 1'b1 || req_plate !== 16'h1001) begin errors++; $display("FAIL ovf_head got vld=%0h plate=%0h exp 1/1001", req_valid, req_plate); end
    tick();
    checks++; if (drop_pulse !== 1'b0) begin errors++; $display("FAIL ovf_pulse_width got drop=%0h exp 0", drop_pulse); end
    req_ready = 1'b1; in_mode = 1'b1; license_plate = 16'h1006;
    tick();
    in_mode = 1'b0; license_plate = 16'h0;
    checks++; if (drop_pulse !== 1'b0 || queue_count !== 3'd4 || busy !== 1'b1) begin errors++; $display("FAIL fullpop got drop=%0h cnt=%0d busy=%0h exp 0/4/1", drop_pulse, queue_count, busy); end
    op_done = 1'b1; tick(); op_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (req_valid !== 1'b1 || req_plate !== exp_plates[i]) begin errors++; $display("FAIL drain_%0d got vld=%0h plate=%0h exp 1/%0h", i, req_valid, req_plate, exp_plates[i]); end
      tick();
      op_done = 1'b1; tick(); op_done = 1'b0;
    end
    checks++; if (queue_count !== 3'd0) begin errors++; $display("FAIL drain_empty got cnt=%0d exp 0", queue_count); end
    req_ready = 1'b0;
    tick();
  endtask

  task automatic test_illegal();
    in_mode = 1'b1; out_mode = 1'b1; license_plate = 16'h2222;
    tick();
    in_mode = 1'b0; out_mode = 1'b0; license_plate = 16'h0;
    checks++; if (drop_pulse !== 1'b1 || queue_count !== 3'd0) begin errors++; $display("FAIL ill_both got drop=%0h cnt=%0d exp 1/0", drop_pulse, queue_count); end
    tick();
    checks++; if (drop_pulse !== 1'b0) begin errors++; $display("FAIL ill_clear got drop=%0h exp 0", drop_pulse); end
    out_mode = 1'b1; license_plate = 16'h0;
    tick();
    out_mode = 1'b0;
    checks++; if (drop_pulse !== 1'b1 || queue_count !== 3'd0) begin errors++; $display("FAIL ill_zero got drop=%0h cnt=%0d exp 1/0", drop_pulse, queue_count); end
    leakage = 1'b1; leakage_floor = 3'd0;
    tick();
    leakage = 1'b0;
    checks++; if (drop_pulse !== 1'b0 || queue_count !== 3'd0) begin errors++; $display("FAIL ill_floor0 got drop=%0h cnt=%0d exp 0/0", drop_pulse, queue_count); end
    tick();
    checks++; if (req_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ill_floor0_idle got vld=%0h busy=%0h exp 0/0", req_valid, busy); end
  endtask

  task automatic test_timeout();
    req_ready = 1'b1;
    in_mode = 1'b1; license_plate = 16'h3333;
    tick();
    in_mode = 1'b0; license_plate = 16'h0;
    tick();
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL tmo_start got busy=%0h exp 1", busy); end
    repeat (63) tick();
    checks++; if (busy !== 1'b1 || timeout_pulse !== 1'b0) begin errors++; $display("FAIL tmo_early got busy=%0h tmo=%0h exp 1/0", busy, timeout_pulse); end
    tick();
    checks++; if (timeout_pulse !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL tmo_fire got tmo=%0h busy=%0h exp 1/0", timeout_pulse, busy); end
    tick();
    checks++; if (timeout_pulse !== 1'b0 || req_valid !== 1'b0 || queue_count !== 3'd0) begin errors++; $display("FAIL tmo_after got tmo=%0h vld=%0h cnt=%0d exp 0/0/0", timeout_pulse, req_valid, queue_count); end
    req_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    req_ready = 1'b0;
    in_mode = 1'b1; license_plate = 16'h4444; tick();
    license_plate = 16'h5555; tick();
    in_mode = 1'b0; license_plate = 16'h0;
    checks++; if (req_valid !== 1'b1 || queue_count !== 3'd2) begin errors++; $display("FAIL rmid_offer got vld=%0h cnt=%0d exp 1/2", req_valid, queue_count); end
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (req_valid !== 1'b0 || queue_count !== 3'd0 || req_plate !== 16'h0) begin errors++; $display("FAIL rmid_reset got vld=%0h cnt=%0d plate=%0h exp 0/0/0", req_valid, queue_count, req_plate); end
    tick();
    checks++; if (req_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_lost got vld=%0h busy=%0h exp 0/0", req_valid, busy); end
  endtask

  initial begin
    test_reset();
    test_single_in();
    test_priority();
    test_overflow_and_full_pop();
    test_illegal();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/parking_request_scheduler.md
Name: parking_request_scheduler

Overview:
Sits between the user-facing request inputs (in_mode/out_mode/license_plate/leakage) and the elevator/parking FSM inside parking_lot_top. It buffers park-in and park-out requests in a small FIFO and records per-floor leakage evacuation requests. It issues exactly one command at a time to the elevator FSM over a valid/ready handshake, then waits for completion. Evacuation commands always take priority over queued in/out requests.

Parameters:
DEPTH, 4, FIFO entries (legal 2..7)
TIMEOUT, 64, max cycles in BUSY before forced abort (legal 2..255)

Ports:
clock  in  1  system clock, all state updates on posedge
reset  in  1  synchronous, active-high; clears all state
in_mode  in  1  park-in request strobe (sampled each posedge)
out_mode  in  1  park-out request strobe
license_plate  in  16  4-digit BCD plate accompanying in_mode/out_mode
leakage  in  1  leakage report strobe
leakage_floor  in  3  floor of leakage, 1..7
req_ready  in  1  elevator FSM can accept a command
op_done  in  1  one-cycle pulse: accepted command finished
req_valid  out  1  command offered
req_kind  out  2  00 park-in, 01 park-out, 10 evacuate, 11 unused
req_plate  out  16  plate for in/out; 0 for evacuate
req_floor  out  3  floor for evacuate; 0 for in/out
busy  out  1  high in BUSY state
queue_count  out  3  FIFO occupancy
drop_pulse  out  1  one-cycle pulse: request discarded
timeout_pulse  out  1  one-cycle pulse: BUSY aborted

Behaviour:
- Reset: FIFO emptied, evac mask = 0, state IDLE, all outputs 0.
- Enqueue at posedge when exactly one of in_mode/out_mode is high and license_plate != 0; entry = {kind, plate}.
- Enqueue allowed if queue_count < DEPTH, or FIFO pops in the same cycle (full + simultaneous accept -> enqueue succeeds, count unchanged).
- Drop (drop_pulse=1 next cycle, nothing stored): in_mode and out_mode both high; plate == 0 with either mode high; FIFO full with no pop.
- Leakage: at posedge with leakage=1 and leakage_floor in 1..7, set evac_mask[leakage_floor]; already set -> no-op; floor 0 ignored, no drop_pulse. Leakage and an in/out request in the same cycle are both processed.
- FSM states: IDLE, OFFER, BUSY.
- IDLE: if evac_mask != 0, load evacuate command for lowest set floor; else if FIFO non-empty, load head entry. Then -> OFFER, req_valid=1 from the next cycle. Latency: request sampled at edge N -> FIFO written at N -> req_valid high after edge N+1.
- OFFER: req_valid held; req_kind/plate/floor stable until accepted. A newly arriving leakage does not preempt an offered command. Transfer when req_valid && req_ready at posedge: pop FIFO (in/out) or clear evac_mask bit (evac); req_valid -> 0; -> BUSY.
- BUSY: busy=1; cycle counter starts at 0 and increments. op_done=1 -> IDLE. Counter reaches TIMEOUT-1 without op_done -> timeout_pulse, -> IDLE; the command is not re-queued. op_done in IDLE/OFFER ignored.
- Back-to-back: op_done at edge M -> IDLE; next command offered after edge M+1.
- FIFO pointers wrap modulo DEPTH; queue_count exact 0..DEPTH.
- Reset mid-operation (any state): immediate return to reset values; pending and offered commands lost.

Test Plan:
- Single park-in: plate 0x9423, in_mode 1 cycle, req_ready=1 -> req_valid two edges later with kind 00, plate 0x9423; busy next cycle; op_done -> IDLE, queue_count 0.
- Priority: queue 0x8754 (out), then leakage floor 3 and floor 5 while BUSY; op_done -> offers evac floor 3, then floor 5, then out 0x8754.
- Overflow: req_ready=0, enqueue 5 distinct plates with DEPTH=4 -> queue_count 4, drop_pulse on 5th; first offered plate = first enqueued.
- Full + pop same cycle: FIFO full, req_ready rises in the same cycle a new in_mode arrives -> no drop, queue_count stays 4.
- Illegal inputs: in_mode & out_mode both high -> drop_pulse; plate 0 -> drop_pulse; leakage_floor 0 -> no state change.
- Timeout and reset: accept a command, withhold op_done for 64 cycles -> timeout_pulse, IDLE. Assert reset while OFFER -> req_valid 0, queue_count 0 next cycle.
